// File: rtl/quantum_pkg.sv
// Shared Q15.16 constants, amplitude width and scheduler FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package quantum_pkg;

  localparam int AMP_W = 32;

  localparam logic [AMP_W-1:0] ONE  = 32'h0001_0000;
  localparam logic [AMP_W-1:0] ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_MEAS  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WRITE = 3'd5,
    ST_ACK   = 3'd6
  } meas_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among requesters, starting one past the previous grant.
// Latency: combinational.
// Backpressure: none; the caller samples grant_idx only when it can accept a grant.
module rr_arbiter #(
  parameter int NQ = 4,
  parameter int QW = $clog2(NQ)
) (
  input  logic [NQ-1:0] req,
  input  logic [QW-1:0] last_grant,
  output logic [QW-1:0] grant_idx,
  output logic          grant_valid
);

  // Walk the requesters from last_grant+1 with wrap, first hit wins.
  always_comb begin
    int          idx;
    logic [QW-1:0] sel;
    idx         = 0;
    sel         = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= NQ; k++) begin
      idx = (int'(last_grant) + k) % NQ;
      sel = QW'(idx);
      if (!grant_valid && req[sel]) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
    end
  end

endmodule

// File: rtl/measurement_scheduler.sv
// Serialises qubit measurement requests onto one shared measurement unit.
// Latency: 6 cycles req-in-IDLE to ack when meas_done follows meas_en by one cycle.
// Backpressure: req is a held level; one operation at a time, others wait in IDLE arbitration.
module measurement_scheduler
  import quantum_pkg::*;
#(
  parameter int NQ      = 4,
  parameter int TIMEOUT = 16,
  parameter int QW      = $clog2(NQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NQ-1:0]    req,
  output logic [NQ-1:0]    ack,
  output logic             result,
  output logic             busy,
  output logic             rd_en,
  output logic [QW-1:0]    rd_sel,
  input  logic [AMP_W-1:0] prob_0,
  output logic             lfsr_step,
  output logic             meas_en,
  output logic [AMP_W-1:0] meas_prob,
  input  logic             meas_done,
  input  logic             meas_bit,
  input  logic [AMP_W-1:0] meas_alpha,
  input  logic [AMP_W-1:0] meas_beta,
  output logic             wr_en,
  output logic [QW-1:0]    wr_sel,
  output logic [AMP_W-1:0] wr_alpha,
  output logic [AMP_W-1:0] wr_beta,
  output logic             timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  meas_state_t      state_q, state_d;
  logic [QW-1:0]    cur_q, cur_d;
  logic [QW-1:0]    last_grant_q, last_grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_q, bit_d;
  logic [NQ-1:0]    ack_q, ack_d;
  logic             result_q, result_d;
  logic             busy_q, busy_d;
  logic             rd_en_q, rd_en_d;
  logic [QW-1:0]    rd_sel_q, rd_sel_d;
  logic             lfsr_step_q, lfsr_step_d;
  logic             meas_en_q, meas_en_d;
  logic [AMP_W-1:0] meas_prob_q, meas_prob_d;
  logic             wr_en_q, wr_en_d;
  logic [QW-1:0]    wr_sel_q, wr_sel_d;
  logic [AMP_W-1:0] wr_alpha_q, wr_alpha_d;
  logic [AMP_W-1:0] wr_beta_q, wr_beta_d;
  logic             timeout_err_q, timeout_err_d;

  logic [QW-1:0]    grant_idx;
  logic             grant_valid;

  rr_arbiter #(.NQ(NQ), .QW(QW)) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  // Next-state sequencing; strobes are decoded from the next state so they leave a flop.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    meas_prob_d   = meas_prob_q;
    wr_alpha_d    = wr_alpha_q;
    wr_beta_d     = wr_beta_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          cur_d   = grant_idx;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        meas_prob_d = prob_0;
        state_d     = ST_MEAS;
      end
      ST_MEAS: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (meas_done) begin
          bit_d      = meas_bit;
          wr_alpha_d = meas_alpha;
          wr_beta_d  = meas_beta;
          state_d    = ST_WRITE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Unit never answered: report a 0 and leave the state store untouched.
          timeout_err_d = 1'b1;
          bit_d         = 1'b0;
          state_d       = ST_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: state_d = ST_ACK;
      ST_ACK: begin
        last_grant_d = cur_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    rd_en_d     = (state_d == ST_FETCH);
    rd_sel_d    = (state_d == ST_FETCH) ? cur_d : rd_sel_q;
    lfsr_step_d = (state_d == ST_LATCH);
    meas_en_d   = (state_d == ST_MEAS);
    wr_en_d     = (state_d == ST_WRITE);
    wr_sel_d    = (state_d == ST_WRITE) ? cur_d : wr_sel_q;
    ack_d       = '0;
    result_d    = 1'b0;
    if (state_d == ST_ACK) begin
      ack_d[cur_d] = 1'b1;
      result_d     = bit_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cur_q         <= '0;
      last_grant_q  <= QW'(NQ - 1);
      cnt_q         <= '0;
      bit_q         <= 1'b0;
      ack_q         <= '0;
      result_q      <= 1'b0;
      busy_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_sel_q      <= '0;
      lfsr_step_q   <= 1'b0;
      meas_en_q     <= 1'b0;
      meas_prob_q   <= ZERO;
      wr_en_q       <= 1'b0;
      wr_sel_q      <= '0;
      wr_alpha_q    <= ONE;
      wr_beta_q     <= ZERO;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      ack_q         <= ack_d;
      result_q      <= result_d;
      busy_q        <= busy_d;
      rd_en_q       <= rd_en_d;
      rd_sel_q      <= rd_sel_d;
      lfsr_step_q   <= lfsr_step_d;
      meas_en_q     <= meas_en_d;
      meas_prob_q   <= meas_prob_d;
      wr_en_q       <= wr_en_d;
      wr_sel_q      <= wr_sel_d;
      wr_alpha_q    <= wr_alpha_d;
      wr_beta_q     <= wr_beta_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ack         = ack_q;
  assign result      = result_q;
  assign busy        = busy_q;
  assign rd_en       = rd_en_q;
  assign rd_sel      = rd_sel_q;
  assign lfsr_step   = lfsr_step_q;
  assign meas_en     = meas_en_q;
  assign meas_prob   = meas_prob_q;
  assign wr_en       = wr_en_q;
  assign wr_sel      = wr_sel_q;
  assign wr_alpha    = wr_alpha_q;
  assign wr_beta     = wr_beta_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_measurement_scheduler.sv
// Scoreboard bench for measurement_scheduler with state-store and measurement-unit models.
// Latency: n/a.
// Backpressure: n/a.
module tb_measurement_scheduler;
  import quantum_pkg::*;

  localparam int NQ      = 4;
  localparam int TIMEOUT = 16;
  localparam int QW      = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NQ-1:0] req;
  logic [NQ-1:0] ack;
  logic          result, busy, rd_en, lfsr_step, meas_en, wr_en, timeout_err;
  logic [QW-1:0] rd_sel, wr_sel;
  logic [31:0]   prob_0, meas_prob, meas_alpha, meas_beta, wr_alpha, wr_beta;
  logic          meas_done, meas_bit;

  measurement_scheduler #(.NQ(NQ), .TIMEOUT(TIMEOUT), .QW(QW)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .result(result), .busy(busy),
    .rd_en(rd_en), .rd_sel(rd_sel), .prob_0(prob_0), .lfsr_step(lfsr_step),
    .meas_en(meas_en), .meas_prob(meas_prob), .meas_done(meas_done), .meas_bit(meas_bit),
    .meas_alpha(meas_alpha), .meas_beta(meas_beta), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_alpha(wr_alpha), .wr_beta(wr_beta), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int sel; logic [31:0] a; logic [31:0] b; int cyc; } wr_t;
  typedef struct { logic [3:0] oh; logic res; int cyc; logic terr; } ack_t;

  wr_t  exp_wr[$];
  ack_t exp_ack[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] prob_mem [NQ];

  // model state
  int   lg_m = NQ - 1;
  int   cur_m = 0;
  bit   op_active = 0;
  int   rd_cyc = 0;
  logic [3:0] req_prev = '0;
  bit   terr_m = 0;
  int   wr_cnt = 0, ack_cnt = 0;
  logic [31:0] last_wr_a, last_wr_b;

  // measurement-unit stimulus controls
  bit   force_mode = 1, force_to = 0, force_bit = 0, spur_en = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within cycle budget (cycle %0d)", nm, cyc);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int lg);
    for (int k = 1; k <= NQ; k++)
      if (r[(lg + k) % NQ]) return (lg + k) % NQ;
    return -1;
  endfunction

  // Monitor: compare every DUT strobe against the model/scoreboard.
  always @(negedge clk) begin : mon
    int   n_str;
    int   w;
    wr_t  ew;
    ack_t ea;
    n_str = int'(rd_en) + int'(lfsr_step) + int'(meas_en) + int'(wr_en) + int'(ack != 0);
    if (n_str > 0) begin
      check("strobe_exclusive", 64'(n_str <= 1), 64'd1);
      check("busy_during_op", 64'(busy), 64'd1);
    end
    if (rd_en) begin
      w = rr_pick(req_prev, lg_m);
      check("rd_grant_legal", 64'(w >= 0 && !op_active), 64'd1);
      if (w >= 0) begin
        check("rd_sel", 64'(rd_sel), 64'(w));
        cur_m = w;
        lg_m  = w;
      end
      op_active = 1;
      rd_cyc    = cyc;
    end
    if (lfsr_step) check("lfsr_step_cycle", 64'(cyc), 64'(rd_cyc + 1));
    if (meas_en) begin
      check("meas_en_cycle", 64'(cyc), 64'(rd_cyc + 2));
      check("meas_prob", 64'(meas_prob), 64'(prob_mem[cur_m]));
    end
    if (wr_en) begin
      wr_cnt++;
      last_wr_a = wr_alpha;
      last_wr_b = wr_beta;
      check("wr_pending", 64'(exp_wr.size() > 0), 64'd1);
      if (exp_wr.size() > 0) begin
        ew = exp_wr.pop_front();
        check("wr_sel", 64'(wr_sel), 64'(ew.sel));
        check("wr_alpha", 64'(wr_alpha), 64'(ew.a));
        check("wr_beta", 64'(wr_beta), 64'(ew.b));
        check("wr_cycle", 64'(cyc), 64'(ew.cyc));
      end
    end
    if (ack != 0) begin
      ack_cnt++;
      check("ack_pending", 64'(exp_ack.size() > 0), 64'd1);
      if (exp_ack.size() > 0) begin
        ea = exp_ack.pop_front();
        check("ack_onehot", 64'(ack), 64'(ea.oh));
        check("ack_result", 64'(result), 64'(ea.res));
        check("ack_cycle", 64'(cyc), 64'(ea.cyc));
        check("ack_timeout_err", 64'(timeout_err), 64'(ea.terr));
      end
      op_active = 0;
    end
    req_prev = req;
    if (reset) begin
      exp_wr.delete();
      exp_ack.delete();
      op_active = 0;
      lg_m      = NQ - 1;
    end
  end

  // State store and measurement unit models; push expectations when a measurement starts.
  bit   rd_pend = 0;
  logic [QW-1:0] rd_addr = '0;
  bit   have_op = 0, resp = 0;
  int   meas_cyc = 0, resp_cyc = 0;
  logic r_bit;
  logic [31:0] r_a, r_b;

  initial begin
    meas_done = 1'b0; meas_bit = 1'b0; meas_alpha = '0; meas_beta = '0; prob_0 = '0;
  end

  always @(negedge clk) begin : resp_model
    int d;
    bit to;
    logic [3:0] oh;
    prob_0  = rd_pend ? prob_mem[rd_addr] : $urandom;
    rd_pend = rd_en;
    rd_addr = rd_sel;
    meas_done  = 1'b0;
    meas_bit   = 1'($urandom);
    meas_alpha = $urandom;
    meas_beta  = $urandom;
    if (reset) begin
      have_op = 0;
      terr_m  = 0;
    end else if (meas_en) begin
      to    = force_mode ? force_to : ($urandom_range(0, 5) == 0);
      d     = force_mode ? 1 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT)
                                                           : $urandom_range(1, 3));
      r_bit = force_mode ? force_bit : 1'($urandom);
      r_a   = force_mode ? (r_bit ? ZERO : ONE) : $urandom;
      r_b   = force_mode ? (r_bit ? ONE : ZERO) : $urandom;
      oh    = 4'b0001 << cur_m;
      have_op  = 1;
      meas_cyc = cyc;
      if (to) begin
        resp   = 0;
        terr_m = 1;
        exp_ack.push_back('{oh, 1'b0, cyc + TIMEOUT + 1, 1'b1});
      end else begin
        resp     = 1;
        resp_cyc = cyc + d;
        exp_wr.push_back('{cur_m, r_a, r_b, cyc + d + 1});
        exp_ack.push_back('{oh, r_bit, cyc + d + 2, terr_m});
      end
    end else if (have_op && resp && cyc == resp_cyc) begin
      meas_done  = 1'b1;
      meas_bit   = r_bit;
      meas_alpha = r_a;
      meas_beta  = r_b;
      have_op    = 0;
    end else if (spur_en && !(have_op && cyc > meas_cyc && cyc <= meas_cyc + TIMEOUT)
                 && $urandom_range(0, 7) == 0) begin
      meas_done = 1'b1;
    end
  end

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(output logic [3:0] a, output logic r, output int c, input int limit);
    a = '0; r = 1'b0; c = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        a = ack; r = result; c = cyc;
        return;
      end
    end
    bound_fail("wait_ack");
  endtask

  task automatic wait_strobe(input bit use_meas, input string nm);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (use_meas ? meas_en : lfsr_step) return;
    end
    bound_fail(nm);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check({tag, "_rd_sel"}, 64'(rd_sel), 64'd0);
    check({tag, "_lfsr_step"}, 64'(lfsr_step), 64'd0);
    check({tag, "_meas_en"}, 64'(meas_en), 64'd0);
    check({tag, "_meas_prob"}, 64'(meas_prob), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_sel"}, 64'(wr_sel), 64'd0);
    check({tag, "_wr_alpha"}, 64'(wr_alpha), 64'h0001_0000);
    check({tag, "_wr_beta"}, 64'(wr_beta), 64'd0);
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  logic [3:0] order [5];
  logic [3:0] a;
  logic       r;
  int         c, t0, w0, a0;

  initial begin
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < NQ; i++) prob_mem[i] = $urandom;
    prob_mem[0] = 32'h0000_C000;
    reset = 1'b1;
    req   = '0;
    repeat (3) at_drive();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // single request, bit 0
    at_drive();
    req = 4'b0001; t0 = cyc;
    wait_ack(a, r, c, 40);
    check("single_ack", 64'(a), 64'b0001);
    check("single_result", 64'(r), 64'd0);
    check("single_latency", 64'(c - t0), 64'd6);
    check("single_wr_alpha", 64'(last_wr_a), 64'h0001_0000);
    check("single_wr_beta", 64'(last_wr_b), 64'd0);
    at_drive();
    req = '0;

    // contention from reset
    at_drive();
    reset = 1'b1; req = 4'b1111;
    at_drive(); at_drive();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, r, c, 40);
      check("rr_order", 64'(a), 64'(order[k]));
    end
    at_drive();
    reset = 1'b1; req = '0;
    at_drive();
    reset = 1'b0;

    // timeout
    force_to = 1;
    at_drive();
    req = 4'b0001; t0 = cyc; w0 = wr_cnt;
    wait_ack(a, r, c, 60);
    check("to_ack", 64'(a), 64'b0001);
    check("to_result", 64'(r), 64'd0);
    check("to_err", 64'(timeout_err), 64'd1);
    check("to_latency", 64'(c - t0), 64'd20);
    check("to_no_write", 64'(wr_cnt), 64'(w0));
    at_drive();
    req = '0;

    // reset mid-WAIT
    at_drive();
    reset = 1'b1;
    at_drive();
    reset = 1'b0;
    at_drive();
    req = 4'b0001;
    wait_strobe(1'b1, "wait_meas_en");
    repeat (3) @(negedge clk);
    at_drive();
    reset = 1'b1; req = '0;
    at_drive();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    a0 = ack_cnt; w0 = wr_cnt;
    repeat (25) @(negedge clk);
    check("midrst_no_ack", 64'(ack_cnt), 64'(a0));
    check("midrst_no_wr", 64'(wr_cnt), 64'(w0));
    force_to = 0;
    at_drive();
    req = 4'b0100; t0 = cyc;
    wait_ack(a, r, c, 40);
    check("midrst_next_ack", 64'(a), 64'b0100);
    check("midrst_next_latency", 64'(c - t0), 64'd6);
    at_drive();
    req = '0;

    // drop request during MEAS, bit 1
    force_bit = 1;
    at_drive();
    req = 4'b0010;
    wait_strobe(1'b0, "wait_lfsr_step");
    at_drive();
    req = '0;
    wait_ack(a, r, c, 40);
    check("drop_ack", 64'(a), 64'b0010);
    check("drop_result", 64'(r), 64'd1);
    check("drop_wr_alpha", 64'(last_wr_a), 64'd0);
    check("drop_wr_beta", 64'(last_wr_b), 64'h0001_0000);

    // randomized traffic
    force_mode = 0;
    spur_en    = 1;
    for (int i = 0; i < 3000; i++) begin
      at_drive();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
      req = req & ~ack;
      if ($urandom_range(0, 39) == 0) req[$urandom_range(0, NQ - 1)] = 1'b0;
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, NQ - 1)] = 1'b1;
    end
    at_drive();
    reset = 1'b0;
    req   = '0;
    repeat (60) at_drive();
    check("drain_ack_queue", 64'(exp_ack.size()), 64'd0);
    check("drain_wr_queue", 64'(exp_wr.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
